// File: rtl/con_updown_param.sv
// con_updown_param: bounded up/down counter with wrap/saturate modes, parallel load,
// out-of-range recovery, and terminal-count, wrap and error flags.
module con_updown_param #(
  parameter int WIDTH   = 3,
  parameter int RST_VAL = 4
) (
  input  logic             clk,
  input  logic             res,
  input  logic             en,
  input  logic             x,
  input  logic             mode,
  input  logic             ld,
  input  logic [WIDTH-1:0] ld_val,
  input  logic [WIDTH-1:0] lo,
  input  logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrp,
  output logic             err,
  output logic             cfg_err
);
  localparam logic [WIDTH-1:0] RV  = WIDTH'(RST_VAL);
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);
  logic [WIDTH-1:0] q_q, q_d;
  logic wrp_q, wrp_d, err_q, err_d;
  logic at_hi, at_lo, ld_ok, out_rng;
  assign cfg_err = lo > hi;
  assign at_hi   = q_q == hi;
  assign at_lo   = q_q == lo;
  assign ld_ok   = (ld_val >= lo) && (ld_val <= hi);
  assign out_rng = (q_q < lo) || (q_q > hi);
  assign tc      = en & (x ? at_lo : at_hi);
  // Bound check precedes the +/-1, so the arithmetic never wraps past the range.
  always_comb begin
    q_d   = q_q;
    wrp_d = 1'b0;
    err_d = 1'b0;
    if (!cfg_err) begin
      if (ld) begin
        q_d   = ld_ok ? ld_val : lo;
        err_d = !ld_ok;
      end else if (out_rng) begin
        q_d   = lo;
        err_d = 1'b1;
      end else if (en) begin
        wrp_d = x ? at_lo : at_hi;
        q_d   = !wrp_d ? (x ? q_q - ONE : q_q + ONE) : mode ? q_q : (x ? hi : lo);
      end
    end
  end
  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      q_q   <= RV;
      wrp_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      wrp_q <= wrp_d;
      err_q <= err_d;
    end
  end
  assign q   = q_q;
  assign wrp = wrp_q;
  assign err = err_q;
endmodule

// File: tb/tb_con_updown_param.sv
// tb_con_updown_param: scoreboard bench for a 3-bit and an 8-bit counter against an
// arithmetic reference model of the counting rules.
module tb_con_updown_param;
  typedef struct {int q; bit wrp; bit err;} exp_t;

  logic clk = 1'b0;
  logic res = 1'b0;
  logic en0, x0, mode0, ld0, tc0, wrp0, err0, cfg0;
  logic [2:0] ldv0, lo0, hi0, q0;
  logic en1, x1, mode1, ld1, tc1, wrp1, err1, cfg1;
  logic [7:0] ldv1, lo1, hi1, q1;
  int tests = 0, fails = 0;
  int m0, m1;
  exp_t sb0[$], sb1[$];

  always #5 clk = ~clk;

  con_updown_param #(.WIDTH(3), .RST_VAL(4)) dut0 (
    .clk(clk), .res(res), .en(en0), .x(x0), .mode(mode0), .ld(ld0), .ld_val(ldv0),
    .lo(lo0), .hi(hi0), .q(q0), .tc(tc0), .wrp(wrp0), .err(err0), .cfg_err(cfg0));

  con_updown_param #(.WIDTH(8), .RST_VAL(0)) dut1 (
    .clk(clk), .res(res), .en(en1), .x(x1), .mode(mode1), .ld(ld1), .ld_val(ldv1),
    .lo(lo1), .hi(hi1), .q(q1), .tc(tc1), .wrp(wrp1), .err(err1), .cfg_err(cfg1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: range treated as a ring of (hi-lo+1) slots for wrap, clamped for saturate.
  function automatic exp_t nxt(int q, bit en, bit x, bit mode, bit ld, int ldv, int lo, int hi);
    exp_t r;
    int span, off;
    r.q = q; r.wrp = 0; r.err = 0;
    if (lo > hi) return r;
    if (ld) begin
      if (ldv >= lo && ldv <= hi) r.q = ldv;
      else begin r.q = lo; r.err = 1; end
      return r;
    end
    if (q < lo || q > hi) begin r.q = lo; r.err = 1; return r; end
    if (!en) return r;
    span = hi - lo + 1;
    off  = q - lo;
    if (!x) begin
      r.wrp = (q == hi);
      r.q   = mode ? ((q == hi) ? q : q + 1) : lo + (off + 1) % span;
    end else begin
      r.wrp = (q == lo);
      r.q   = mode ? ((q == lo) ? q : q - 1) : lo + (off - 1 + span) % span;
    end
    return r;
  endfunction

  // Called at a falling edge with inputs already set; returns at the next falling edge.
  task automatic step();
    exp_t e;
    #1;
    chk("tc0", tc0, en0 && (x0 ? m0 == int'(lo0) : m0 == int'(hi0)));
    chk("cfg_err0", cfg0, lo0 > hi0);
    chk("tc1", tc1, en1 && (x1 ? m1 == int'(lo1) : m1 == int'(hi1)));
    chk("cfg_err1", cfg1, lo1 > hi1);
    e = nxt(m0, en0, x0, mode0, ld0, ldv0, lo0, hi0); sb0.push_back(e); m0 = e.q;
    e = nxt(m1, en1, x1, mode1, ld1, ldv1, lo1, hi1); sb1.push_back(e); m1 = e.q;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic async_reset();
    #3 res = 1'b0;
    #1;
    chk("rst_q0", q0, 4);
    chk("rst_wrp0", wrp0, 0);
    chk("rst_err0", err0, 0);
    chk("rst_q1", q1, 0);
    m0 = 4; m1 = 0;
    @(posedge clk);
    @(negedge clk);
    res = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb0.size() != 0) begin
        e = sb0.pop_front();
        chk("q0", q0, e.q); chk("wrp0", wrp0, e.wrp); chk("err0", err0, e.err);
      end
      if (sb1.size() != 0) begin
        e = sb1.pop_front();
        chk("q1", q1, e.q); chk("wrp1", wrp1, e.wrp); chk("err1", err1, e.err);
      end
    end
  end

  initial begin : driver
    logic [7:0] a, b;
    {en0, x0, mode0, ld0, ldv0, lo0, hi0} = {1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 3'd7};
    {en1, x1, mode1, ld1, ldv1, lo1, hi1} = {1'b1, 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd255};
    m0 = 4; m1 = 0;
    repeat (2) @(negedge clk);
    chk("init_q0", q0, 4);
    chk("init_q1", q1, 0);
    chk("init_wrp0", wrp0, 0);
    res = 1'b1;
    repeat (5) step();
    en1 = 1'b0;
    // Down/saturate from 4 inside [2,5], then reverse.
    {ld0, ldv0, lo0, hi0} = {1'b1, 3'd4, 3'd2, 3'd5};
    step();
    {ld0, x0, mode0} = {1'b0, 1'b1, 1'b1};
    repeat (4) step();
    x0 = 1'b0;
    step();
    // Loads: in range, out of range, load beating enable.
    {ld0, ldv0} = {1'b1, 3'd3}; step();
    ldv0 = 3'd6; step();
    ld0 = 1'b0; step();
    {ld0, ldv0, en0} = {1'b1, 3'd5, 1'b1}; step();
    // Bound change forces recovery.
    {lo0, hi0, ldv0, en0} = {3'd0, 3'd7, 3'd7, 1'b0}; step();
    {ld0, hi0} = {1'b0, 3'd5}; step();
    step();
    // Mid-count async reset, then frozen bad configuration.
    en0 = 1'b1; repeat (2) step();
    async_reset();
    {lo0, hi0, ld0, ldv0} = {3'd6, 3'd2, 1'b1, 3'd3};
    repeat (3) step();
    {lo0, hi0, ld0} = {3'd3, 3'd3, 1'b0};
    repeat (3) step();
    for (int i = 0; i < 300; i++) begin
      if (i == 150) async_reset();
      {en0, x0, mode0} = 3'($urandom);
      ld0 = $urandom_range(0, 7) == 0;
      ldv0 = 3'($urandom);
      if ($urandom_range(0, 3) == 0) begin
        a = 8'($urandom_range(0, 7)); b = 8'($urandom_range(0, 7));
        if ($urandom_range(0, 9) != 0 && a > b) {a, b} = {b, a};
        lo0 = a[2:0]; hi0 = b[2:0];
      end
      {en1, x1, mode1} = 3'($urandom);
      ld1 = $urandom_range(0, 7) == 0;
      ldv1 = 8'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        a = 8'($urandom); b = 8'($urandom);
        if ($urandom_range(0, 9) != 0 && a > b) {a, b} = {b, a};
        lo1 = a; hi1 = b;
      end
      step();
    end
    @(posedge clk);
    #2;
    chk("sb_drained", sb0.size() + sb1.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/con_updown_param.md
# con_updown_param

Parametrised up/down counter for the contador family. It generalises the fixed 3-bit direction-controlled counter (reset value 4, forced recovery from illegal codes) to `WIDTH` bits with run-time bounds, wrap or saturate mode, parallel load, count enable, terminal-count and wrap flags. It is used as the sequencing counter behind display and timing blocks that need a counter with a configurable range.

## Interface
Parameters:
- `WIDTH`, 3: counter width in bits, valid range 2..16.
- `RST_VAL`, 4: value of `q` on reset, truncated to `WIDTH` bits.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `res`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: count enable.
- `x`, input, 1: direction. 0 = up, 1 = down.
- `mode`, input, 1: bound behaviour. 0 = wrap, 1 = saturate.
- `ld`, input, 1: synchronous parallel load.
- `ld_val`, input, WIDTH: value to load.
- `lo`, input, WIDTH: lower bound, inclusive, unsigned.
- `hi`, input, WIDTH: upper bound, inclusive, unsigned.
- `q`, output, WIDTH: count value, registered.
- `tc`, output, 1: terminal count, combinational. Equals `en & ~x & (q==hi)` or `en & x & (q==lo)`.
- `wrp`, output, 1: registered. One-cycle pulse following a bound event.
- `err`, output, 1: registered. One-cycle pulse following a recovery or a rejected load.
- `cfg_err`, output, 1: combinational. Equals `lo > hi`.

## Operation
- Reset (`res` = 0), effective immediately and independent of `clk`:
  - `q` = RST_VAL, `wrp` = 0, `err` = 0.
  - Outputs hold these values until the first rising edge after `res` returns to 1.
- `cfg_err` = 1 freezes the counter. `q` holds, `ld` is ignored, `wrp` = 0, `err` = 0. No other rule below applies.
- Otherwise, each rising edge applies exactly one rule. Priority is highest first:
  1. `ld` = 1, `lo` ≤ `ld_val` ≤ `hi`: `q` ← `ld_val`. `wrp` ← 0, `err` ← 0.
  2. `ld` = 1, `ld_val` out of range: `q` ← `lo`, `err` ← 1.
  3. Recovery, `q` < `lo` or `q` > `hi`: `q` ← `lo`, `err` ← 1.
     - Applies regardless of `en`.
     - This is the successor of the fixed illegal-code reset.
  4. `en` = 1, up, `q` < `hi`: `q` ← `q`+1.
  5. `en` = 1, down, `q` > `lo`: `q` ← `q`−1.
  6. `en` = 1, up, `q` == `hi`:
     - Wrap mode: `q` ← `lo`, `wrp` ← 1.
     - Saturate mode: `q` holds, `wrp` ← 1.
  7. `en` = 1, down, `q` == `lo`:
     - Wrap mode: `q` ← `hi`, `wrp` ← 1.
     - Saturate mode: `q` holds, `wrp` ← 1.
  8. `en` = 0: `q` holds.
- `wrp` and `err` are 0 on every edge where their setting rule did not fire. They never stay high for two cycles from a single event.
- Arithmetic is unsigned and modulo 2^WIDTH. A bound check always precedes the ±1, so no overflow reaches `q`.
- `lo` == `hi`: the counter stays at that value.
  - With `en` = 1, `wrp` pulses every cycle in both modes.
  - `tc` stays 1 while `en` = 1.
- `x`, `mode`, `lo` and `hi` may change on any cycle. They are sampled at each edge, and the new bounds apply immediately, including recovery.
- An out-of-range `RST_VAL` is legal. The first edge after reset recovers `q` to `lo` and pulses `err`.

## Timing
- Latency from `ld`/`en` to `q` is one cycle. `wrp` and `err` are valid in the same cycle as the `q` update they describe.
- `tc` is combinational from `q`, `en`, `x`, `lo` and `hi`. Its purpose is cascading, with no cycle delay.
- Reset assertion mid-count overrides any pending load or count without waiting for an edge.
- Reset release: the first edge after release with `en` = 1 performs a normal count from RST_VAL.
- Outputs are glitch-free registers, except `tc` and `cfg_err`.

## Test plan
- **Reset and up-count.** WIDTH=3, RST_VAL=4, `lo`=0, `hi`=7, `mode`=0, `x`=0, `en`=1.
  - Required `q`: 4,5,6,7,0,1.
  - `wrp` is high only in the cycle `q` becomes 0.
  - `tc` = 1 while `q`=7.
- **Down and saturate.** `lo`=2, `hi`=5, `x`=1, `mode`=1, starting from 4.
  - Required `q`: 3,2,2,2.
  - `wrp` pulses on each hold at 2.
  - Switching `x` to 0 then gives 3.
- **Load.**
  - `ld_val`=3 with `lo`=2, `hi`=5: `q`=3, `err`=0.
  - `ld_val`=6: `q`=2, `err`=1 for one cycle.
  - `ld` beats `en` on the same edge.
- **Bound change and recovery.** `q`=7, `en`=0, then `hi` changes to 5.
  - Next edge: `q`=`lo`, `err`=1.
  - The following edge: `err`=0.
- **Async reset mid-count and bad configuration.**
  - Drop `res` between edges: `q`=RST_VAL before the next edge.
  - Set `lo`=6, `hi`=2: `cfg_err`=1, `q` frozen, `ld` ignored.
- **Wide parameters.** WIDTH=8, RST_VAL=0, `lo`=0, `hi`=255, down-count in wrap mode.
  - Required `q`: 0→255→254.
  - `wrp` pulses once, at the 255 transition.
